pc_sequencer: RTL

- Program-counter and instruction-issue block for the front end; sits directly upstream of fetch_decode_buffer.
- Owns the PC register and drives the instruction-memory address.
- Presents one 16-bit instruction word per cycle to the fetch/decode buffer.
- Arbitrates PC sources (sequential, branch/jump target, RET/RTI popped PC, interrupt vector) and runs the interrupt-entry sequence.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_next_mux.sv | 34 +++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared front-end definitions: PC geometry, fixed instruction words,
// sequencer state encoding and next-PC source encoding.
package cpu_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 16;

  localparam logic [PC_WIDTH-1:0]    RESET_PC       = 16'h0000;
  localparam logic [PC_WIDTH-1:0]    INT_VEC_ADDR   = 16'h0001;
  localparam logic [INSTR_WIDTH-1:0] INT_PUSH_INSTR = 16'hF800;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR      = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_INT_PUSH = 2'd1,
    ST_INT_VEC  = 2'd2
  } seq_state_e;

  // Which source won the next-PC arbitration this cycle.
  typedef enum logic [2:0] {
    SEL_POP    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_HOLD   = 3'd2,
    SEL_INT    = 3'd3,
    SEL_SEQ    = 3'd4
  } pc_sel_e;

  // Sequential successor; wraps modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the PC sequencer: instruction-memory address/data
// and the issue stream handed to the fetch/decode buffer.
interface pc_sequencer_if;
  import cpu_pkg::*;

  logic [PC_WIDTH-1:0]    o_imem_addr;
  logic [INSTR_WIDTH-1:0] i_imem_data;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic [PC_WIDTH-1:0]    o_pc;
  logic [PC_WIDTH-1:0]    o_saved_pc;
  logic                   o_int_ack;

  modport master (
    output o_imem_addr,
    input  i_imem_data,
    output o_instr,
    output o_pc,
    output o_saved_pc,
    output o_int_ack
  );

  modport slave (
    input  o_imem_addr,
    output i_imem_data,
    input  o_instr,
    input  o_pc,
    input  o_saved_pc,
    input  o_int_ack
  );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority selector:
// pop > branch > stall (hold) > interrupt (hold, capture) > sequential.
module pc_next_mux import cpu_pkg::*; (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                pop_i,
  input  logic [PC_WIDTH-1:0] pop_data_i,
  input  logic                branch_i,
  input  logic [PC_WIDTH-1:0] target_i,
  input  logic                stall_i,
  input  logic                int_i,
  output logic [PC_WIDTH-1:0] next_pc_o,
  output pc_sel_e             sel_o
);

  // Priority chain; an accepted interrupt holds the PC so it becomes the return address.
  always_comb begin
    next_pc_o = pc_inc(pc_i);
    sel_o     = SEL_SEQ;
    if (pop_i) begin
      next_pc_o = pop_data_i;
      sel_o     = SEL_POP;
    end else if (branch_i) begin
      next_pc_o = target_i;
      sel_o     = SEL_BRANCH;
    end else if (stall_i) begin
      next_pc_o = pc_i;
      sel_o     = SEL_HOLD;
    end else if (int_i) begin
      next_pc_o = pc_i;
      sel_o     = SEL_INT;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and instruction issue for the front end, including the
// interrupt-entry sequence (bubble, push of the saved PC, vector fetch).
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_RUN      | normal issue of imem[PC]; redirects and interrupt accept
//   ST_INT_PUSH | issue INT_PUSH_INSTR with o_int_ack; redirect aborts entry
//   ST_INT_VEC  | read handler address from INT_VEC_ADDR, load it into PC
module pc_sequencer import cpu_pkg::*; (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_stall,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic                i_pop_pc,
  input  logic [PC_WIDTH-1:0] i_pop_data,
  input  logic                i_interrupt,
  pc_sequencer_if.master      fe_if
);

  seq_state_e             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    saved_pc_q, saved_pc_d;
  logic                   pending_q, pending_d;

  logic [PC_WIDTH-1:0]    mux_next_pc;
  pc_sel_e                mux_sel;
  logic                   mux_int;

  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   int_ack;

  // In RUN a same-cycle request counts so the current word becomes the return
  // address; in INT_PUSH the request is already committed, so only a redirect
  // or a stall can keep us from advancing to INT_VEC.
  assign mux_int = (state_q == ST_RUN) ? (pending_q | i_interrupt) : 1'b1;

  pc_next_mux u_next_mux (
    .pc_i       (pc_q),
    .pop_i      (i_pop_pc),
    .pop_data_i (i_pop_data),
    .branch_i   (i_branch_taken),
    .target_i   (i_branch_target),
    .stall_i    (i_stall),
    .int_i      (mux_int),
    .next_pc_o  (mux_next_pc),
    .sel_o      (mux_sel)
  );

  // State, PC, return-address and pending-request registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      saved_pc_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
      pending_q  <= pending_d;
    end
  end

  // Next-state, next-PC and issue outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    pending_d  = pending_q;
    imem_addr  = pc_q;
    instr      = NOP_INSTR;
    int_ack    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        instr     = fe_if.i_imem_data;
        pending_d = pending_q | i_interrupt;
        pc_d      = mux_next_pc;
        if (mux_sel == SEL_INT) begin
          // The current word is dropped and re-fetched after the handler returns.
          instr      = NOP_INSTR;
          saved_pc_d = pc_q;
          state_d    = ST_INT_PUSH;
        end
      end

      ST_INT_PUSH: begin
        instr   = INT_PUSH_INSTR;
        int_ack = 1'b1;
        case (mux_sel)
          SEL_POP, SEL_BRANCH: begin
            // Older instruction redirected: abandon entry, request stays pending.
            instr   = NOP_INSTR;
            int_ack = 1'b0;
            pc_d    = mux_next_pc;
            state_d = ST_RUN;
          end
          SEL_HOLD: ;
          default: begin
            pending_d = 1'b0;
            state_d   = ST_INT_VEC;
          end
        endcase
      end

      ST_INT_VEC: begin
        // Nothing older than the push can redirect, so only stall matters here.
        imem_addr = INT_VEC_ADDR;
        if (!i_stall) begin
          pc_d    = fe_if.i_imem_data;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (i_reset) begin
      instr   = NOP_INSTR;
      int_ack = 1'b0;
    end
  end

  assign fe_if.o_imem_addr = imem_addr;
  assign fe_if.o_instr     = instr;
  assign fe_if.o_pc        = pc_q;
  assign fe_if.o_saved_pc  = saved_pc_q;
  assign fe_if.o_int_ack   = int_ack;

endmodule
